// File: rtl/frame_ram_pkg.sv
// frame_ram_pkg: shared frame RAM geometry and reader state encoding
package frame_ram_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int RAM_DEPTH = 2 ** ADDR_W;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/ram_rd_skid_fifo.sv
// ram_rd_skid_fifo: 2-entry FIFO absorbing RAM read data; dout is the head entry
module ram_rd_skid_fifo #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dout,
  output logic              out_valid,
  output logic [1:0]        occ
);
  logic [DATA_W-1:0] tail;
  logic pop;
  assign out_valid = occ != 2'd0;
  assign pop = out_valid && out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dout <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (pop) dout <= (push && occ == 2'd1) ? din : tail;
      else if (push && occ == 2'd0) dout <= din;
      if (push && occ == (pop ? 2'd2 : 2'd1)) tail <= din;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: streams a contiguous frame RAM block out as valid/ready bytes
module ram_stream_reader #(
  parameter int ADDR_W = frame_ram_pkg::ADDR_W,
  parameter int DATA_W = frame_ram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] read_address,
  input  logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);
  import frame_ram_pkg::*;
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  state_t state, state_nx;
  logic [ADDR_W:0] len_q, issued;
  logic [1:0] occ;
  logic in_flight, pop, issue, last_issue, drained, accept;
  assign accept = state == IDLE && start;
  assign pop = m_valid && m_ready;
  // The RAM samples read_address on the issuing edge, so data lands one edge later;
  // counting the in-flight byte against free slots means it can never be dropped.
  assign issue = state == RUN && issued < len_q &&
                 ({1'b0, occ} + {2'b0, in_flight}) < (3'd2 + {2'b0, pop});
  assign last_issue = issue && issued + (ADDR_W+1)'(1) == len_q;
  assign drained = !in_flight && (occ == 2'd0 || (occ == 2'd1 && pop));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE  ? (start ? (length == '0 ? DONE : RUN) : IDLE) :
               state == RUN   ? (last_issue ? DRAIN : RUN) :
               state == DRAIN ? (drained ? DONE : DRAIN) : IDLE;
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      read_address <= '0;
      issued       <= '0;
      len_q        <= '0;
      in_flight    <= 1'b0;
    end else begin
      in_flight <= issue;
      if (accept) begin
        read_address <= base_addr;
        issued       <= '0;
        len_q        <= length > MAX_LEN ? MAX_LEN : length;
      end else if (issue) begin
        read_address <= read_address + ADDR_W'(1);
        issued       <= issued + (ADDR_W+1)'(1);
      end
    end
  ram_rd_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(in_flight),
    .din(q),
    .out_ready(m_ready),
    .dout(m_data),
    .out_valid(m_valid),
    .occ(occ)
  );
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: randomized checks of the RAM stream reader against a queue model
module tb_ram_stream_reader;
  logic clk = 0, rst = 1, start = 0, m_ready = 0, m_valid, busy, done;
  logic [11:0] base_addr = 0, read_address;
  logic [12:0] length = 0;
  logic [7:0] q = 0, m_data;
  logic [7:0] mem [4096];
  int errors = 0, checks = 0;
  int cyc = 0, k_cyc, first_cyc, last_cyc, done_cyc, done_cnt, stall_viol, max_lead;
  int n_exp, bad_idx;
  logic [7:0] bad_got, bad_exp, hold_d;
  logic [11:0] cur_base, lead;
  bit valid_seen, hold_v, timed_out;
  logic [7:0] got [$];

  ram_stream_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .read_address(read_address), .q(q), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    q <= mem[read_address];
    cyc <= cyc + 1;
  end

  // Observe the stream mid-cycle: beats, done pulses, stall stability, read lead.
  always @(negedge clk)
    if (rst) hold_v = 0;
    else begin
      lead = read_address - cur_base - 12'(got.size());
      if (busy && int'(lead) > max_lead) max_lead = int'(lead);
      if (hold_v && (!m_valid || m_data !== hold_d)) stall_viol++;
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
      if (m_valid) valid_seen = 1;
      if (m_valid && m_ready) begin
        if (got.size() == 0) first_cyc = cyc;
        last_cyc = cyc;
        got.push_back(m_data);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end

  function automatic logic rdy(input int mode, input int i);
    int pat [6] = '{1, 0, 0, 1, 0, 1};
    return mode == 0 ? 1'b1 : mode == 1 ? pat[i % 6] != 0 : mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  // Drives one command and collects it; the expected stream comes from mem directly.
  task automatic xfer(input logic [11:0] b, input logic [12:0] l, input int mode, input int restart_at);
    got.delete();
    done_cnt = 0; valid_seen = 0; stall_viol = 0; max_lead = 0; cur_base = b;
    start = 1; base_addr = b; length = l; m_ready = rdy(mode, 0);
    @(posedge clk); #1;
    k_cyc = cyc;
    start = 0;
    for (int i = 1; i < 20000; i++) begin
      m_ready = rdy(mode, i);
      start = i == restart_at;
      if (i == restart_at) begin base_addr = b + 12'd100; length = 13'd5; end
      @(posedge clk); #1;
      if (done_cnt != 0) break;
    end
    timed_out = done_cnt == 0;
    start = 0; m_ready = 1;
    @(posedge clk); #1;
    n_exp = l > 13'd4096 ? 4096 : int'(l);
    bad_idx = -1;
    for (int j = 0; j < got.size() && j < n_exp; j++)
      if (bad_idx < 0 && got[j] !== mem[b + 12'(j)]) begin
        bad_idx = j; bad_got = got[j]; bad_exp = mem[b + 12'(j)];
      end
  endtask

  task automatic test_reset;
    checks++; if (read_address !== 12'h000) begin errors++; $display("FAIL reset_addr got=%h want=000", read_address); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h want=00", m_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
  endtask

  task automatic test_basic;
    xfer(12'h010, 13'd4, 0, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout got=no_done want=done"); end
    checks++; if (got.size() !== 4) begin errors++; $display("FAIL basic_count got=%0d want=4", got.size()); end
    checks++; if (bad_idx !== -1) begin errors++; $display("FAIL basic_data idx=%0d got=%h want=%h", bad_idx, bad_got, bad_exp); end
    checks++; if (first_cyc !== k_cyc + 2) begin errors++; $display("FAIL basic_first got=%0d want=%0d", first_cyc - k_cyc, 2); end
    checks++; if (last_cyc !== k_cyc + 5) begin errors++; $display("FAIL basic_last got=%0d want=%0d", last_cyc - k_cyc, 5); end
    checks++; if (done_cyc !== k_cyc + 6) begin errors++; $display("FAIL basic_done got=%0d want=%0d", done_cyc - k_cyc, 6); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_cnt got=%0d want=1", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_wrap;
    xfer(12'hFFE, 13'd4, 0, 0);
    checks++; if (got.size() !== 4) begin errors++; $display("FAIL wrap_count got=%0d want=4", got.size()); end
    checks++; if (bad_idx !== -1) begin errors++; $display("FAIL wrap_data idx=%0d got=%h want=%h", bad_idx, bad_got, bad_exp); end
    checks++; if (read_address !== 12'h002) begin errors++; $display("FAIL wrap_addr_end got=%h want=002", read_address); end
  endtask

  task automatic test_backpressure;
    xfer(12'h000, 13'd8, 1, 0);
    checks++; if (got.size() !== 8) begin errors++; $display("FAIL bp_count got=%0d want=8", got.size()); end
    checks++; if (bad_idx !== -1) begin errors++; $display("FAIL bp_data idx=%0d got=%h want=%h", bad_idx, bad_got, bad_exp); end
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL bp_stable got=%0d want=0", stall_viol); end
    checks++; if (max_lead > 2) begin errors++; $display("FAIL bp_lead got=%0d want<=2", max_lead); end
  endtask

  task automatic test_zero_and_saturate;
    xfer(12'h123, 13'd0, 0, 0);
    checks++; if (done_cyc !== k_cyc) begin errors++; $display("FAIL zero_done got=%0d want=0", done_cyc - k_cyc); end
    checks++; if (valid_seen !== 1'b0) begin errors++; $display("FAIL zero_valid got=%b want=0", valid_seen); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_cnt got=%0d want=1", done_cnt); end
    xfer(12'h7A5, 13'h1FFF, 0, 0);
    checks++; if (got.size() !== 4096) begin errors++; $display("FAIL sat_count got=%0d want=4096", got.size()); end
    checks++; if (bad_idx !== -1) begin errors++; $display("FAIL sat_data idx=%0d got=%h want=%h", bad_idx, bad_got, bad_exp); end
    checks++; if (done_cyc !== k_cyc + 4098) begin errors++; $display("FAIL sat_done got=%0d want=4098", done_cyc - k_cyc); end
  endtask

  task automatic test_restart_ignored;
    xfer(12'h200, 13'd10, 0, 3);
    checks++; if (got.size() !== 10) begin errors++; $display("FAIL restart_count got=%0d want=10", got.size()); end
    checks++; if (bad_idx !== -1) begin errors++; $display("FAIL restart_data idx=%0d got=%h want=%h", bad_idx, bad_got, bad_exp); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL restart_done_cnt got=%0d want=1", done_cnt); end
  endtask

  task automatic test_random;
    for (int t = 0; t < 12; t++) begin
      xfer(12'($urandom), 13'($urandom_range(1, 40)), 2, 0);
      checks++; if (got.size() !== n_exp) begin errors++; $display("FAIL rand%0d_count got=%0d want=%0d", t, got.size(), n_exp); end
      checks++; if (bad_idx !== -1) begin errors++; $display("FAIL rand%0d_data idx=%0d got=%h want=%h", t, bad_idx, bad_got, bad_exp); end
      checks++; if (stall_viol !== 0 || max_lead > 2) begin errors++; $display("FAIL rand%0d_flow stall=%0d lead=%0d want=0,<=2", t, stall_viol, max_lead); end
    end
  endtask

  task automatic test_mid_reset;
    got.delete(); cur_base = 12'h300; max_lead = 0;
    start = 1; base_addr = 12'h300; length = 13'd8; m_ready = 0;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL mrst_full_valid got=%b want=1", m_valid); end
    #2 rst = 1;
    #1;
    checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mrst_async got=%b%b%b want=000", m_valid, busy, done);
    end
    @(posedge clk); #1;
    got.delete(); valid_seen = 0; m_ready = 1;
    rst = 0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (valid_seen !== 1'b0 || got.size() !== 0) begin
      errors++; $display("FAIL mrst_residual got=%0d beats want=0", got.size());
    end
    xfer(12'h555, 13'd6, 0, 0);
    checks++; if (got.size() !== 6) begin errors++; $display("FAIL mrst_after_count got=%0d want=6", got.size()); end
    checks++; if (bad_idx !== -1) begin errors++; $display("FAIL mrst_after_data idx=%0d got=%h want=%h", bad_idx, bad_got, bad_exp); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    rst = 0;
    @(posedge clk); #1;
    test_basic;
    test_wrap;
    test_backpressure;
    test_zero_and_saturate;
    test_restart_ignored;
    test_random;
    test_mid_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Reads a contiguous block from the single-clock 4096x8 frame RAM through its read port and emits the bytes as a valid/ready byte stream.
- Drives the RAM `read_address` and absorbs its 1-cycle registered read latency with a 2-entry skid buffer, so throughput is 1 byte/clk under full backpressure-free flow.
- Sits between the RAM read port and downstream consumers (UART/display formatters); the RAM write port is owned by the fill logic.

Parameters:
- ADDR_W, 12, RAM address width; depth = 2**ADDR_W.
- DATA_W, 8, RAM/stream data width.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle command strobe; sampled only in IDLE
- base_addr  in  ADDR_W  first RAM address of transfer
- length  in  ADDR_W+1  byte count, 0..2**ADDR_W; larger values saturate to 2**ADDR_W
- read_address  out  ADDR_W  registered address to RAM read port
- q  in  DATA_W  RAM registered read data (valid 1 clk after address sampled)
- m_data  out  DATA_W  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready; transfer when m_valid&&m_ready
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after final byte transfers

Behaviour:
- Reset (async): state=IDLE, read_address=0, m_valid=0, m_data=0, busy=0, done=0, counters=0, buffer empty, in-flight flag cleared. Mid-transfer reset aborts the transfer immediately; no residual bytes are emitted after rst deasserts.
- States:
  - IDLE → RUN on start with length≠0.
  - IDLE → DONE on start with length=0.
  - RUN → DRAIN when the last read has been issued.
  - DRAIN → DONE when the buffer is empty and nothing is in flight after the final handshake.
  - DONE → IDLE unconditionally; done=1 only in DONE.
- busy=1 in RUN/DRAIN/DONE.
- Start sampled at edge k in IDLE:
  - read_address=base_addr after edge k.
  - q=mem[base_addr] after edge k+1.
  - Captured into the buffer at edge k+2; m_valid=1, m_data=mem[base_addr] after edge k+2.
- Issue rule: a read is issued (read_address advances, in-flight flag set for the next cycle) only when issued<length and buffer occupancy + in-flight + (pop this cycle ? -1 : 0) < 2. This guarantees the byte returning from the RAM always has a free slot; no byte is ever dropped or duplicated.
- Address arithmetic: read_address increments modulo 2**ADDR_W. A transfer with base=0xFFE, length=4 reads 0xFFE, 0xFFF, 0x000, 0x001.
- Throughput: with m_ready held high, one byte per clock. A length-N transfer completes its final handshake at edge k+N+1; done pulses in the following cycle.
- Backpressure: m_data/m_valid hold stable while m_valid&&!m_ready (AXI-style). Issuing stalls once 2 bytes are buffered or in flight; it resumes the cycle after m_ready returns.
- Simultaneous push (returning q) and pop in the same cycle: occupancy unchanged, order preserved.
- start while busy: ignored; base_addr/length are only captured on accepted start.
- RAM read-during-write returns new data; coherence with concurrent writes is the caller's responsibility.

Decomposition:
- Shared package (frame_ram_pkg): ADDR_W, DATA_W, RAM_DEPTH constants; state enum {IDLE, RUN, DRAIN, DONE}.
- One sub-module: ram_rd_skid_fifo. 2-entry DATA_W FIFO with push/pop, valid/ready out, and occupancy output used by the issue rule.
- Top: FSM, address/issue counter, in-flight flag.

Test Plan:
- RAM preloaded mem[i]=i[7:0]; start base=0x010, length=4, m_ready=1 → m_valid from edge k+2 for 4 cycles, m_data 0x10, 0x11, 0x12, 0x13; done pulses 1 clk after last beat; busy=0 next cycle.
- base=0xFFE, length=4 → read_address sequence 0xFFE, 0xFFF, 0x000, 0x001; m_data FE, FF, 00, 01.
- length=8, m_ready toggled 1,0,0,1,0,1... → exactly 8 transfers, bytes 0x00..0x07 in order, no gaps/duplicates; m_data stable while stalled; read_address never advances more than 2 ahead of the last popped byte.
- length=0 → done pulses in the cycle after start, m_valid never asserts; length=13'h1FFF → saturates, 4096 bytes streamed.
- start re-pulsed mid-transfer with a different base → ignored, original stream completes unchanged.
- rst asserted mid-transfer with 2 bytes buffered → m_valid, busy, done drop to 0 asynchronously; after release, a new start streams correctly from its base.
